// File: rtl/mipi_frame_decoder.sv
// mipi_frame_decoder: receive side of the MIPI frame link.
// Un-swaps the wire byte order, hunts for SOF, checks metadata, pushes payload
// bytes into the downstream FIFO, checks EOF and reports frame status.
// Optional build macro: MIPI_DEC_STRICT_PAD_EN (upper 16 pad bits and unused
// payload bytes must be zero inside a frame, otherwise the frame aborts with code 5).
module mipi_frame_decoder #(
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned TIMEOUT    = 1023,
  parameter logic [7:0]  FRAME_TYPE = 8'h02
) (
  input  logic        rx_pixel_clk,
  input  logic        rst,
  input  logic [63:0] mipi_data,
  input  logic        mipi_valid,
  input  logic        fifo_full,
  output logic [7:0]  fifo_wdata,
  output logic        fifo_we,
  output logic [7:0]  meta_channel,
  output logic        frame_done,
  output logic        frame_err,
  output logic [2:0]  err_code,
  output logic        overflow,
  output logic [15:0] frame_cnt,
  output logic [2:0]  state
);

  localparam logic [2:0] S_HUNT      = 3'd0;
  localparam logic [2:0] S_META      = 3'd1;
  localparam logic [2:0] S_PAYLOAD   = 3'd2;
  localparam logic [2:0] S_CHECK_EOF = 3'd3;

  localparam logic [2:0] E_TYPE    = 3'd1;
  localparam logic [2:0] E_LEN     = 3'd2;
  localparam logic [2:0] E_EOF     = 3'd3;
  localparam logic [2:0] E_TIMEOUT = 3'd4;
  localparam logic [2:0] E_PAD     = 3'd5;

  localparam logic [47:0] SOF_WORD = 48'hEAFF99DEADFF;
  localparam logic [47:0] EOF_WORD = 48'hEAFF99DEADAA;

  localparam logic [23:0] MAX_LEN_L = 24'(MAX_LEN);

  // Idle counter only needs to reach TIMEOUT-1; the next idle cycle aborts.
  localparam int unsigned    TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]  TO_LIM = TW'(TIMEOUT - 1);

  // Frame word in transmit order: the wire carries byte 0 of the frame in d[7:0].
  logic [47:0] f;
  assign f = {mipi_data[7:0],   mipi_data[15:8],  mipi_data[23:16],
              mipi_data[31:24], mipi_data[39:32], mipi_data[47:40]};

  logic [7:0]  meta_type;
  logic [23:0] meta_len;
  assign meta_type = f[47:40];
  assign meta_len  = f[39:16];

  logic in_frame;
  assign in_frame = (state != S_HUNT);

  logic pad_bad;
`ifdef MIPI_DEC_STRICT_PAD_EN
  // Pad bits must be clear on every frame word; payload words carry only f[7:0].
  assign pad_bad = in_frame &&
                   ((mipi_data[63:48] != 16'h0) ||
                    ((state == S_PAYLOAD) && (f[47:8] != 40'h0)));
`else
  logic pad_unused;
  assign pad_unused = ^mipi_data[63:48];
  assign pad_bad    = 1'b0;
`endif

  logic [23:0]   remaining;
  logic [TW-1:0] to_cnt;

  logic [2:0]    nxt_state;
  logic [23:0]   nxt_rem;
  logic [TW-1:0] nxt_to;
  logic          wr_byte;
  logic          drop_byte;
  logic          good_eof;
  logic          err_hit;
  logic [2:0]    err_nxt;
  logic          load_chan;

  // Next-state decode: timeout on idle cycles, word handling on valid cycles.
  always_comb begin
    nxt_state = state;
    nxt_rem   = remaining;
    nxt_to    = to_cnt;
    wr_byte   = 1'b0;
    drop_byte = 1'b0;
    good_eof  = 1'b0;
    err_hit   = 1'b0;
    err_nxt   = 3'd0;
    load_chan = 1'b0;

    if (!mipi_valid) begin
      if (in_frame) begin
        if (to_cnt == TO_LIM) begin
          err_hit = 1'b1;
          err_nxt = E_TIMEOUT;
        end else begin
          nxt_to = to_cnt + TW'(1);
        end
      end
    end else begin
      nxt_to = '0;
      if (pad_bad) begin
        err_hit = 1'b1;
        err_nxt = E_PAD;
      end else begin
        case (state)
          S_HUNT: begin
            if (f == SOF_WORD) nxt_state = S_META;
          end
          S_META: begin
            // A repeated SOF just restarts metadata parsing.
            if (f == SOF_WORD) begin
              nxt_state = S_META;
            end else if (meta_type != FRAME_TYPE) begin
              err_hit = 1'b1;
              err_nxt = E_TYPE;
            end else if ((meta_len == 24'd0) || (meta_len > MAX_LEN_L)) begin
              err_hit = 1'b1;
              err_nxt = E_LEN;
            end else begin
              load_chan = 1'b1;
              nxt_rem   = meta_len;
              nxt_state = S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            // A full FIFO drops the byte but the frame keeps going.
            if (fifo_full) drop_byte = 1'b1;
            else           wr_byte   = 1'b1;
            nxt_rem = remaining - 24'd1;
            if (remaining == 24'd1) nxt_state = S_CHECK_EOF;
          end
          S_CHECK_EOF: begin
            if (f == EOF_WORD) begin
              good_eof  = 1'b1;
              nxt_state = S_HUNT;
            end else begin
              err_hit = 1'b1;
              err_nxt = E_EOF;
            end
          end
          default: nxt_state = S_HUNT;
        endcase
      end
    end

    // Any abort returns to HUNT; the offending word is not re-examined as SOF.
    if (err_hit) begin
      nxt_state = S_HUNT;
      nxt_to    = '0;
    end
  end

  // FSM, remaining-word and idle counters.
  always_ff @(posedge rx_pixel_clk) begin
    if (rst) begin
      state     <= S_HUNT;
      remaining <= '0;
      to_cnt    <= '0;
    end else begin
      state     <= nxt_state;
      remaining <= nxt_rem;
      to_cnt    <= nxt_to;
    end
  end

  // FIFO write port: byte appears one cycle after its word is accepted.
  always_ff @(posedge rx_pixel_clk) begin
    if (rst) begin
      fifo_we    <= 1'b0;
      fifo_wdata <= 8'h00;
    end else begin
      fifo_we <= wr_byte;
      if (wr_byte) fifo_wdata <= f[7:0];
    end
  end

  // Frame status: done/err pulses, held error code, good-frame counter.
  always_ff @(posedge rx_pixel_clk) begin
    if (rst) begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 3'd0;
      frame_cnt  <= 16'h0000;
    end else begin
      frame_done <= good_eof;
      frame_err  <= err_hit;
      if (err_hit)  err_code  <= err_nxt;
      if (good_eof) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Metadata channel latch and sticky overflow flag.
  always_ff @(posedge rx_pixel_clk) begin
    if (rst) begin
      meta_channel <= 8'h00;
      overflow     <= 1'b0;
    end else begin
      if (load_chan) meta_channel <= f[15:8];
      if (drop_byte) overflow     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mipi_frame_decoder.sv
// Bench for mipi_frame_decoder: directed frames from the test plan followed by
// randomized frames, every cycle compared against a frame-level reference model.
module tb_mipi_frame_decoder;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 1023;
  localparam logic [7:0]  FTYPE = 8'h02;
  localparam logic [47:0] SOF_F = 48'hEAFF99DEADFF;
  localparam logic [47:0] EOF_F = 48'hEAFF99DEADAA;
`ifdef MIPI_DEC_STRICT_PAD_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic        rx_pixel_clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] mipi_data = '0;
  logic        mipi_valid = 1'b0;
  logic        fifo_full = 1'b0;
  logic [7:0]  fifo_wdata;
  logic        fifo_we;
  logic [7:0]  meta_channel;
  logic        frame_done;
  logic        frame_err;
  logic [2:0]  err_code;
  logic        overflow;
  logic [15:0] frame_cnt;
  logic [2:0]  state;

  mipi_frame_decoder #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .FRAME_TYPE(FTYPE)) dut (
    .rx_pixel_clk(rx_pixel_clk), .rst(rst), .mipi_data(mipi_data),
    .mipi_valid(mipi_valid), .fifo_full(fifo_full), .fifo_wdata(fifo_wdata),
    .fifo_we(fifo_we), .meta_channel(meta_channel), .frame_done(frame_done),
    .frame_err(frame_err), .err_code(err_code), .overflow(overflow),
    .frame_cnt(frame_cnt), .state(state)
  );

  always #5 rx_pixel_clk = ~rx_pixel_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- word helpers ----------------
  function automatic logic [47:0] unswap(input logic [63:0] d);
    logic [47:0] r;
    for (int i = 0; i < 6; i++) r[8*i +: 8] = d[8*(5-i) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] mk(input logic [47:0] fw, input logic [15:0] pad);
    logic [63:0] d;
    d[63:48] = pad;
    for (int i = 0; i < 6; i++) d[8*(5-i) +: 8] = fw[8*i +: 8];
    return d;
  endfunction

  function automatic logic [15:0] rpad();
    return STRICT ? 16'h0 : 16'($urandom);
  endfunction

  // ---------------- reference model ----------------
  // Frame-level view: phase 0 hunting, 1 awaiting metadata, 2 collecting
  // payload (m_left words still due), 3 awaiting EOF.
  int          m_phase = 0;
  int          m_left  = 0;
  int          m_idle  = 0;
  logic [47:0] m_f;
  logic        e_we = 0, e_done = 0, e_err = 0, e_ovf = 0;
  logic [7:0]  e_wdata = 0, e_chan = 0;
  logic [2:0]  e_code = 0;
  logic [15:0] e_cnt = 0;
  bit          chk_en = 0;

  task automatic m_abort(input int c);
    e_err   = 1'b1;
    e_code  = 3'(c);
    m_phase = 0;
    m_idle  = 0;
  endtask

  always @(posedge rx_pixel_clk) begin
    m_f    = unswap(mipi_data);
    e_we   = 1'b0;
    e_done = 1'b0;
    e_err  = 1'b0;
    if (rst) begin
      m_phase = 0; m_left = 0; m_idle = 0;
      e_wdata = 0; e_chan = 0; e_code = 0; e_ovf = 0; e_cnt = 0;
      chk_en  = 1;
    end else if (!mipi_valid) begin
      if (m_phase != 0) begin
        m_idle++;
        if (m_idle == TIMEOUT) m_abort(4);
      end
    end else begin
      m_idle = 0;
      if (STRICT && m_phase != 0 &&
          (mipi_data[63:48] != 0 || (m_phase == 2 && m_f[47:8] != 0))) begin
        m_abort(5);
      end else begin
        case (m_phase)
          0: if (m_f == SOF_F) m_phase = 1;
          1: begin
            if (m_f == SOF_F) m_phase = 1;
            else if (m_f[47:40] != FTYPE) m_abort(1);
            else if (m_f[39:16] == 0 || m_f[39:16] > MAX_LEN) m_abort(2);
            else begin
              e_chan  = m_f[15:8];
              m_left  = int'(m_f[39:16]);
              m_phase = 2;
            end
          end
          2: begin
            if (fifo_full) e_ovf = 1'b1;
            else begin e_we = 1'b1; e_wdata = m_f[7:0]; end
            m_left--;
            if (m_left == 0) m_phase = 3;
          end
          default: begin
            if (m_f == EOF_F) begin
              e_done  = 1'b1;
              e_cnt   = e_cnt + 16'd1;
              m_phase = 0;
            end else m_abort(3);
          end
        endcase
      end
    end
  end

  // ---------------- compare process ----------------
  int         n_wr = 0, n_done = 0, n_ferr = 0;
  logic [7:0] last_byte = 0;

  always @(negedge rx_pixel_clk) begin
    if (chk_en) begin
      chk("fifo_we", fifo_we, e_we);
      if (e_we) chk("fifo_wdata", fifo_wdata, e_wdata);
      chk("frame_done", frame_done, e_done);
      chk("frame_err", frame_err, e_err);
      chk("err_code", err_code, e_code);
      chk("overflow", overflow, e_ovf);
      chk("frame_cnt", frame_cnt, e_cnt);
      chk("meta_channel", meta_channel, e_chan);
      chk("state", state, 32'(m_phase));
      if (fifo_we) begin n_wr++; last_byte = fifo_wdata; end
      if (frame_done) n_done++;
      if (frame_err) n_ferr++;
    end
  end

  // ---------------- drivers ----------------
  task automatic put(input logic [63:0] d, input bit v, input bit full);
    @(negedge rx_pixel_clk);
    mipi_data  = d;
    mipi_valid = v;
    fifo_full  = full;
  endtask

  task automatic w(input logic [63:0] d);
    put(d, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put({$urandom, $urandom}, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic settle();
    idle(2);
    #1;
  endtask

  task automatic do_rst();
    @(negedge rx_pixel_clk);
    rst = 1'b1; mipi_valid = 1'b0;
    @(negedge rx_pixel_clk);
    rst = 1'b0;
    #1;
  endtask

  localparam logic [63:0] NOM_SOF  = 64'h0000FFADDE99FFEA;
  localparam logic [63:0] NOM_META = 64'h0000000101000002;
  localparam logic [63:0] NOM_PAY  = 64'h00005A0000000000;
  localparam logic [63:0] NOM_EOF  = 64'h0000AAADDE99FFEA;

  task automatic rand_frame();
    int          kind;
    int          len;
    logic [23:0] l;
    logic [7:0]  ty;
    kind = $urandom_range(0, 11);
    len  = $urandom_range(1, MAX_LEN);
    repeat ($urandom_range(0, 2)) w(mk({16'h1234, 32'($urandom)}, rpad()));
    w(mk(SOF_F, rpad()));
    if (kind == 1) w(mk(SOF_F, rpad()));
    ty = (kind == 2) ? 8'(FTYPE + 8'($urandom_range(1, 200))) : FTYPE;
    if (kind == 3) l = $urandom_range(0, 1) ? 24'd0 : 24'(MAX_LEN + $urandom_range(1, 5));
    else           l = 24'(len);
    w(mk({ty, l, 8'($urandom), 8'($urandom)}, rpad()));
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      put(mk({STRICT ? 40'h0 : {8'($urandom), 32'($urandom)}, 8'($urandom)}, rpad()),
          1'b1, ($urandom_range(0, 7) == 0));
      if (kind == 5 && i == len / 2) begin
        do_rst();
        return;
      end
    end
    if (kind == 4) w(mk(EOF_F ^ 48'($urandom_range(1, 255)), rpad()));
    else           w(mk(EOF_F, rpad()));
    if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
  endtask

  // ---------------- stimulus ----------------
  int w0, d0, e0;

  initial begin
    repeat (3) @(negedge rx_pixel_clk);
    rst = 1'b0;
    #1;
    // reset state
    chk("rst_state", state, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_we", fifo_we, 0);
    chk("rst_code", err_code, 0);

    // nominal frame
    w0 = n_wr; d0 = n_done;
    w(NOM_SOF); w(NOM_META); w(NOM_PAY); w(NOM_EOF);
    settle();
    chk("nom_writes", 32'(n_wr - w0), 1);
    chk("nom_byte", last_byte, 8'h5A);
    chk("nom_chan", meta_channel, 8'h01);
    chk("nom_done", 32'(n_done - d0), 1);
    chk("nom_cnt", frame_cnt, 1);

    // bad EOF, then a good frame
    do_rst();
    w0 = n_wr; e0 = n_ferr;
    w(NOM_SOF); w(NOM_META); w(NOM_PAY); w(64'h0000BBADDE99FFEA);
    settle();
    chk("beof_writes", 32'(n_wr - w0), 1);
    chk("beof_byte", last_byte, 8'h5A);
    chk("beof_err", 32'(n_ferr - e0), 1);
    chk("beof_code", err_code, 3);
    chk("beof_cnt", frame_cnt, 0);
    w(NOM_SOF); w(NOM_META); w(NOM_PAY); w(NOM_EOF);
    settle();
    chk("beof_next_cnt", frame_cnt, 1);

    // bad lengths
    w0 = n_wr;
    w(NOM_SOF); w(64'h0000000100000002); w(NOM_PAY);
    settle();
    chk("len0_code", err_code, 2);
    chk("len0_writes", 32'(n_wr - w0), 0);
    w(NOM_SOF); w(64'h0000000111000002);
    settle();
    chk("len17_code", err_code, 2);
    chk("len17_state", state, 0);

    // three-byte frame with 5-cycle gaps
    w0 = n_wr; d0 = n_done;
    w(NOM_SOF); w(64'h0000000103000002);
    w(64'h0000110000000000); idle(5);
    w(64'h0000220000000000); idle(5);
    w(64'h0000330000000000);
    w(NOM_EOF);
    settle();
    chk("gap_writes", 32'(n_wr - w0), 3);
    chk("gap_last", last_byte, 8'h33);
    chk("gap_done", 32'(n_done - d0), 1);

    // gap of TIMEOUT-1 survives, gap of TIMEOUT aborts
    d0 = n_done;
    w(NOM_SOF); w(NOM_META); idle(TIMEOUT - 1); w(NOM_PAY); w(NOM_EOF);
    settle();
    chk("gap_max_done", 32'(n_done - d0), 1);
    w(NOM_SOF); w(NOM_META); idle(TIMEOUT);
    settle();
    chk("timeout_code", err_code, 4);
    chk("timeout_state", state, 0);

    // overflow
    w0 = n_wr; d0 = n_done;
    w(NOM_SOF); w(NOM_META); put(64'h0000330000000000, 1'b1, 1'b1); w(NOM_EOF);
    settle();
    chk("ovf_writes", 32'(n_wr - w0), 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_done", 32'(n_done - d0), 1);
    idle(3); #1;
    chk("ovf_sticky", overflow, 1);

    // reset mid-payload
    e0 = n_ferr;
    w(NOM_SOF); w(64'h0000000103000002); w(NOM_PAY);
    do_rst();
    chk("mrst_state", state, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_cnt", frame_cnt, 0);
    chk("mrst_chan", meta_channel, 0);
    chk("mrst_code", err_code, 0);
    settle();
    chk("mrst_noerr", 32'(n_ferr - e0), 0);
    w(NOM_SOF); w(NOM_META); w(NOM_PAY); w(NOM_EOF);
    settle();
    chk("mrst_next_cnt", frame_cnt, 1);

`ifdef MIPI_DEC_STRICT_PAD_EN
    w0 = n_wr;
    w(NOM_SOF); w(NOM_META); w(64'h00015A0000000000);
    settle();
    chk("pad_code", err_code, 5);
    chk("pad_writes", 32'(n_wr - w0), 0);
`endif

    // randomized frames
    for (int k = 0; k < 300; k++) rand_frame();
    settle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
